pipe_alu: RTL
=============

PIPE_ALU -- requirements
Module: pipe_alu

Interface
REQ-001 SHALL provide parameter: WIDTH, 8, operand width in bits (legal range 2..32).
REQ-002 SHALL provide port: clk  input  1  rising-edge clock; the block has one clock.
REQ-003 SHALL provide port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL provide port: in_valid  input  1  request valid.
REQ-005 SHALL provide port: in_ready  output  1  block able to accept a request.
REQ-006 SHALL provide port: opcode  input  4  operation select.
REQ-007 SHALL provide port: a  input  WIDTH  first operand, unsigned.
REQ-008 SHALL provide port: b  input  WIDTH  second operand, unsigned.
REQ-009 SHALL provide port: out_valid  output  1  result valid.
REQ-010 SHALL provide port: out_ready  input  1  consumer accepts result.
REQ-011 SHALL provide port: result  output  2*WIDTH  operation result.
REQ-012 SHALL provide port: err  output  1  illegal opcode or divide-by-zero, qualified by out_valid.

Function
REQ-013 SHALL implement the FSM states IDLE, MUL, DIV and DONE; in_ready = 1 only in IDLE.
REQ-014 SHALL accept a request when in_valid & in_ready at a rising edge, capturing opcode, a and b in that cycle.
REQ-015 SHALL perform add for opcode 4'b0001: result = zero-extended a + zero-extended b, with the carry in bit WIDTH; IDLE->DONE; out_valid on the 1st edge after acceptance.
REQ-016 SHALL perform subtract for opcode 4'b0010: result = (zero-extended a - zero-extended b) mod 2^(2*WIDTH), so a<b yields all-ones upper bits; latency 1.
REQ-017 SHALL perform multiply for opcode 4'b0011 with an iterative shift-add unsigned multiply, one bit per cycle, over exactly WIDTH cycles in MUL; the product SHALL equal a*b and out_valid SHALL assert on the (WIDTH+1)th edge after acceptance.
REQ-018 SHALL treat any other opcode (absent ALU_DIV_EN: 4'b0100 included) as illegal: result = 0, err = 1, latency 1.
REQ-019 SHALL hold out_valid, result and err stable in DONE until out_valid & out_ready, then go DONE->IDLE; in_ready rises the cycle after that edge (no same-cycle re-accept).
REQ-020 SHALL ignore in_valid, opcode, a and b while not in IDLE; changes to them mid-operation SHALL not affect the result.
REQ-021 SHALL not alter result while out_valid = 0, outside of reset.

Reset
REQ-022 SHALL, on rst_n low at any time (including mid-MUL/DIV or in DONE), immediately force state IDLE, out_valid = 0, result = 0 and err = 0, and discard the in-flight operation.
REQ-023 SHALL drive in_ready = 1 while rst_n is high and state is IDLE after reset release.

Configuration
REQ-024 SHALL, with macro ALU_DIV_EN defined, implement opcode 4'b0100 as an unsigned restoring divide in DIV, taking WIDTH cycles with latency WIDTH+1: result[WIDTH-1:0] = a/b and result[2*WIDTH-1:WIDTH] = a%b.
REQ-025 SHALL, with ALU_DIV_EN defined and b == 0, skip DIV and give latency 1, quotient all-ones, remainder = a, err = 1.
REQ-026 SHALL, without ALU_DIV_EN, contain no divider logic and no DIV state, and handle 4'b0100 per REQ-018.

Verification (WIDTH=8)
REQ-027 SHALL cover: add a=200, b=100 -> result 0x012C, err 0, out_valid 1 cycle after accept; sub a=5, b=10 -> 0xFFFB.
REQ-028 SHALL cover: mul a=255, b=255 -> 0xFE01, out_valid exactly 9 cycles after accept, in_ready 0 throughout.
REQ-029 SHALL cover: out_ready held 0 for 5 cycles after add 3+4 -> result 0x0007 held stable; the second request is not accepted until the cycle after the handshake.
REQ-030 SHALL cover: rst_n pulsed low on the 4th cycle of mul 13*11 -> out_valid 0, result 0, in_ready 1 after release; a following mul 13*11 -> 0x008F.
REQ-031 SHALL cover: opcode 4'b1111 -> result 0, err 1; with ALU_DIV_EN, 200/7 -> 0x041C and 9/0 -> 0x09FF with err 1; without it, opcode 4'b0100 -> result 0, err 1.

Source files
------------

// File: rtl/pipe_alu.sv
// Handshaked multi-cycle ALU: add/sub in one cycle, shift-add multiply over WIDTH cycles.
// Define ALU_DIV_EN to add opcode 4'b0100, an unsigned restoring divide over WIDTH cycles.
module pipe_alu #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           opcode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 err
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef ALU_DIV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mul_sum;

  assign in_ready = (state == IDLE);
  assign mul_sum  = acc + (mplier[0] ? mcand : '0);

`ifdef ALU_DIV_EN
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     divisor;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic                 div_fits;
  logic [WIDTH-1:0]     rem_next;
  logic [WIDTH-1:0]     quo_next;

  // A clear borrow bit in the trial subtraction means the divisor fits this step.
  always_comb begin
    div_shift = {rem, quo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, divisor};
    div_fits  = ~div_diff[WIDTH];
    rem_next  = div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    quo_next  = {quo[WIDTH-2:0], div_fits};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      err       <= 1'b0;
      cnt       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
`ifdef ALU_DIV_EN
      quo       <= '0;
      rem       <= '0;
      divisor   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt <= '0;
            case (opcode)
              4'b0001: begin
                result    <= {{WIDTH{1'b0}}, a} + {{WIDTH{1'b0}}, b};
                err       <= 1'b0;
                out_valid <= 1'b1;
                state     <= DONE;
              end
              4'b0010: begin
                result    <= {{WIDTH{1'b0}}, a} - {{WIDTH{1'b0}}, b};
                err       <= 1'b0;
                out_valid <= 1'b1;
                state     <= DONE;
              end
              4'b0011: begin
                mcand  <= {{WIDTH{1'b0}}, a};
                mplier <= b;
                acc    <= '0;
                state  <= MUL;
              end
`ifdef ALU_DIV_EN
              4'b0100: begin
                if (b == '0) begin
                  result    <= {a, {WIDTH{1'b1}}};
                  err       <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= DONE;
                end else begin
                  quo     <= a;
                  rem     <= '0;
                  divisor <= b;
                  state   <= DIV;
                end
              end
`endif
              default: begin
                result    <= '0;
                err       <= 1'b1;
                out_valid <= 1'b1;
                state     <= DONE;
              end
            endcase
          end
        end
        MUL: begin
          acc    <= mul_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            result    <= mul_sum;
            err       <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
`ifdef ALU_DIV_EN
        DIV: begin
          quo <= quo_next;
          rem <= rem_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            result    <= {rem_next, quo_next};
            err       <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
